mac_mgnt_arb: RTL and testbench

- Shares the per-port MAC statistics management interface (sys_req/sys_resp byte-serial protocol) between NUM_REQ requesters, e.g. the SPI slave and the local poller.
- Grants one requester at a time using round-robin arbitration.
- Steers each request to one of NUM_PORT MAC management instances, then assembles the returned MSB-first byte stream into a full register word.
- Sits between the management fabric and the array of per-port MAC ctrl blocks; one transaction is outstanding at a time.

---
 rtl/mac_mgnt_arb_if.sv | 37 +++
 rtl/mac_mgnt_arb.sv | 196 +++++++++++++++++++
 tb/tb_mac_mgnt_arb.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_mgnt_arb_if.sv
// Requester-side and MAC-side signal bundle for mac_mgnt_arb.
// slave is the arbiter's view, master is the surrounding fabric's view.
interface mac_mgnt_arb_if #(
  parameter int NUM_PORT       = 4,
  parameter int NUM_REQ        = 2,
  parameter int MGNT_REG_WIDTH = 32
);
  localparam int PORT_W = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_wr;
  logic [NUM_REQ*PORT_W-1:0] req_port;
  logic [NUM_REQ*8-1:0]      req_addr;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [MGNT_REG_WIDTH-1:0] resp_data;
  logic                      resp_err;
  logic [NUM_PORT-1:0]       mac_req_valid;
  logic                      mac_req_wr;
  logic [7:0]                mac_req_addr;
  logic [NUM_PORT-1:0]       mac_resp_valid;
  logic [NUM_PORT*8-1:0]     mac_resp_data;

  modport slave (
    input  req_valid, req_wr, req_port, req_addr,
    input  mac_resp_valid, mac_resp_data,
    output req_ready, resp_valid, resp_data, resp_err,
    output mac_req_valid, mac_req_wr, mac_req_addr
  );

  modport master (
    output req_valid, req_wr, req_port, req_addr,
    output mac_resp_valid, mac_resp_data,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  mac_req_valid, mac_req_wr, mac_req_addr
  );
endinterface

// File: rtl/mac_mgnt_arb.sv
// Round-robin arbiter sharing the byte-serial MAC statistics
// management interface; one outstanding transaction at a time.
module mac_mgnt_arb #(
  parameter int NUM_PORT       = 4,
  parameter int NUM_REQ        = 2,
  parameter int MGNT_REG_WIDTH = 32,
  parameter int TIMEOUT        = 15
) (
  input  logic           clk_if,
  input  logic           rst_if,
  mac_mgnt_arb_if.slave  bus
);
  localparam int PORT_W = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;
  localparam int RW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NB     = MGNT_REG_WIDTH / 8;
  localparam int TW     = $clog2(TIMEOUT + 3);
  localparam int CW     = $clog2(NB + 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WR_HOLD, WAIT_RD, COLLECT, DONE
  } state_t;

  state_t state, state_n;

  logic [RW-1:0]             rr_q, owner_q, win, rr_n;
  logic                      found, grant;
  logic                      wr_q, wr_n;
  logic [PORT_W-1:0]         port_q, port_n;
  logic [7:0]                addr_q, addr_n;
  logic [MGNT_REG_WIDTH-1:0] data_q;
  logic                      err_q;
  logic [TW-1:0]             tmr_q;
  logic [CW-1:0]             cnt_q;
  logic                      port_ok, sel_v;
  logic [7:0]                sel_b;
  logic                      cap, fail, tick;

  assign port_ok = (32'(port_q) < NUM_PORT);

  // round-robin search from rr_q and capture of the winner's request
  always_comb begin
    found  = 1'b0;
    win    = '0;
    wr_n   = 1'b0;
    port_n = '0;
    addr_n = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && bus.req_valid[j] &&
            ((int'(rr_q) + i) % NUM_REQ) == j) begin
          found = 1'b1;
          win   = RW'(j);
        end
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (win == RW'(j)) begin
        wr_n   = bus.req_wr[j];
        port_n = bus.req_port[j*PORT_W +: PORT_W];
        addr_n = bus.req_addr[j*8 +: 8];
      end
    end
    rr_n = (win == RW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
  end

  // response byte from the latched port only; other ports are ignored
  always_comb begin
    sel_v = 1'b0;
    sel_b = '0;
    for (int p = 0; p < NUM_PORT; p++) begin
      if (PORT_W'(p) == port_q) begin
        sel_v = bus.mac_resp_valid[p];
        sel_b = bus.mac_resp_data[p*8 +: 8];
      end
    end
  end

  // state register
  always_ff @(posedge clk_if or posedge rst_if) begin
    if (rst_if) state <= IDLE;
    else        state <= state_n;
  end

  // next-state and datapath control
  always_comb begin
    state_n = state;
    grant   = 1'b0;
    cap     = 1'b0;
    fail    = 1'b0;
    tick    = 1'b0;
    unique case (state)
      IDLE: begin
        if (found && !rst_if) begin
          grant   = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (!port_ok) begin
          fail    = 1'b1;
          state_n = DONE;
        end else begin
          state_n = wr_q ? WR_HOLD : WAIT_RD;
        end
      end
      WR_HOLD: begin
        if (tmr_q == TW'(2)) state_n = DONE;
        else                 tick    = 1'b1;
      end
      WAIT_RD: begin
        if (sel_v) begin
          cap     = 1'b1;
          state_n = (NB == 1) ? DONE : COLLECT;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          fail    = 1'b1;
          state_n = DONE;
        end else begin
          tick = 1'b1;
        end
      end
      COLLECT: begin
        if (sel_v) begin
          cap = 1'b1;
          if (cnt_q == CW'(NB - 1)) state_n = DONE;
        end else begin
          fail    = 1'b1;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // request latches, rr pointer, timer, byte counter and word assembly
  always_ff @(posedge clk_if or posedge rst_if) begin
    if (rst_if) begin
      rr_q    <= '0;
      owner_q <= '0;
      wr_q    <= 1'b0;
      port_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      tmr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (grant) begin
        rr_q    <= rr_n;
        owner_q <= win;
        wr_q    <= wr_n;
        port_q  <= port_n;
        addr_q  <= addr_n;
        data_q  <= '0;
        err_q   <= 1'b0;
      end
      if (state == ISSUE) begin
        tmr_q <= '0;
        cnt_q <= '0;
      end else if (tick) begin
        tmr_q <= tmr_q + 1'b1;
      end
      if (cap) begin
        data_q <= (data_q << 8) | MGNT_REG_WIDTH'(sel_b);
        cnt_q  <= cnt_q + 1'b1;
      end
      if (fail) err_q <= 1'b1;
    end
  end

  // outputs decoded from state and latches
  always_comb begin
    bus.req_ready     = '0;
    bus.resp_valid    = '0;
    bus.resp_data     = '0;
    bus.resp_err      = 1'b0;
    bus.mac_req_valid = '0;
    bus.mac_req_wr    = 1'b0;
    bus.mac_req_addr  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      bus.req_ready[j]  = grant && (win == RW'(j));
      bus.resp_valid[j] = (state == DONE) && (owner_q == RW'(j));
    end
    for (int p = 0; p < NUM_PORT; p++) begin
      bus.mac_req_valid[p] = (state == ISSUE) && (port_q == PORT_W'(p));
    end
    if (state != IDLE) begin
      bus.mac_req_wr   = wr_q;
      bus.mac_req_addr = addr_q;
    end
    if (state == DONE) begin
      bus.resp_data = data_q;
      bus.resp_err  = err_q;
    end
  end
endmodule

// File: tb/tb_mac_mgnt_arb.sv
// Bench for mac_mgnt_arb: directed and random transactions against
// a transaction-level model of arbitration, latency and read data.
module tb_mac_mgnt_arb;
  localparam int NP = 5;
  localparam int NR = 2;
  localparam int W  = 32;
  localparam int TO = 15;
  localparam int PW = $clog2(NP);

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  mac_mgnt_arb_if #(.NUM_PORT(NP), .NUM_REQ(NR), .MGNT_REG_WIDTH(W)) bus ();

  mac_mgnt_arb #(
    .NUM_PORT(NP), .NUM_REQ(NR), .MGNT_REG_WIDTH(W), .TIMEOUT(TO)
  ) dut (
    .clk_if(clk),
    .rst_if(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int         rr_m = 0;
  bit         rq_wr [NR];
  int         rq_port [NR];
  logic [7:0] rq_addr [NR];
  int         mac_len [NP];
  logic [7:0] mac_b [NP][4];
  bit         noise_en = 1'b0;
  int         cur_port = -1;

  bit         mb_busy [NP];
  int         mb_dly [NP];
  int         mb_sent [NP];
  int         mb_len [NP];
  logic [7:0] mb_byte [NP][4];

  // MAC instances: a read strobe starts a stream of mac_len bytes whose
  // first byte follows three empty cycles; idle ports may chatter
  always @(negedge clk) begin : mac_model
    logic [NP-1:0]   v;
    logic [NP*8-1:0] d;
    v = '0;
    d = '0;
    for (int p = 0; p < NP; p++) begin
      if (mb_busy[p]) begin
        if (mb_dly[p] > 0) mb_dly[p]--;
        else if (mb_sent[p] < mb_len[p]) begin
          v[p] = 1'b1;
          d[p*8 +: 8] = mb_byte[p][mb_sent[p]];
          mb_sent[p]++;
        end else mb_busy[p] = 1'b0;
      end else if (noise_en && p != cur_port) begin
        v[p] = 1'($urandom_range(0, 1));
        d[p*8 +: 8] = 8'($urandom);
      end
      if (bus.mac_req_valid[p] && !bus.mac_req_wr) begin
        mb_busy[p] = 1'b1;
        mb_dly[p]  = 3;
        mb_sent[p] = 0;
        mb_len[p]  = mac_len[p];
        for (int i = 0; i < 4; i++) mb_byte[p][i] = mac_b[p][i];
      end
    end
    bus.mac_resp_valid = v;
    bus.mac_resp_data  = d;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "/ready"}, 64'(bus.req_ready), 64'd0);
    chk({tag, "/rvalid"}, 64'(bus.resp_valid), 64'd0);
    chk({tag, "/rdata"}, 64'(bus.resp_data), 64'd0);
    chk({tag, "/rerr"}, 64'(bus.resp_err), 64'd0);
    chk({tag, "/mvalid"}, 64'(bus.mac_req_valid), 64'd0);
    chk({tag, "/mwr"}, 64'(bus.mac_req_wr), 64'd0);
    chk({tag, "/maddr"}, 64'(bus.mac_req_addr), 64'd0);
  endtask

  task automatic drive_fields();
    for (int r = 0; r < NR; r++) begin
      bus.req_wr[r]            = rq_wr[r];
      bus.req_port[r*PW +: PW] = PW'(rq_port[r]);
      bus.req_addr[r*8 +: 8]   = rq_addr[r];
    end
  endtask

  task automatic set_mac(input int p, input int n, input logic [31:0] w);
    mac_len[p] = n;
    for (int i = 0; i < 4; i++) mac_b[p][i] = w[31-8*i -: 8];
  endtask

  // one arbitration + transaction, starting with the DUT idle
  task automatic round(input logic [NR-1:0] vm, input bit hold_other,
                       input string tag);
    int win, ep, elat, lat, nstb, n;
    logic [NP-1:0] estb, stb;
    logic [W-1:0]  edata, rd;
    logic [NR-1:0] rv;
    logic          eerr, re, swr, extra;
    logic [7:0]    saddr;
    win = -1;
    for (int i = 0; i < NR; i++)
      if (win < 0 && vm[(rr_m + i) % NR]) win = (rr_m + i) % NR;
    ep    = rq_port[win];
    estb  = '0;
    edata = '0;
    eerr  = 1'b0;
    if (ep >= NP) begin
      elat = 2;
      eerr = 1'b1;
    end else begin
      estb[ep] = 1'b1;
      if (rq_wr[win]) elat = 5;
      else begin
        n = mac_len[ep];
        for (int i = 0; i < n; i++)
          edata = (edata << 8) | W'(mac_b[ep][i]);
        if (n == 0) begin
          elat = 2 + TO;
          eerr = 1'b1;
        end else if (n < W / 8) begin
          elat = 6 + n;
          eerr = 1'b1;
        end else elat = 5 + n;
      end
    end
    @(posedge clk); #1;
    drive_fields();
    bus.req_valid = vm;
    #1;
    chk($sformatf("%s/grant", tag), 64'(bus.req_ready), 64'(1) << win);
    rr_m     = (win + 1) % NR;
    cur_port = ep;
    stb   = '0;
    nstb  = 0;
    swr   = 1'b0;
    saddr = '0;
    extra = 1'b0;
    lat   = -1;
    rv    = '0;
    rd    = '0;
    re    = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = hold_other ? (vm & ~(NR'(1) << win)) : '0;
    #1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      if (c > 1) begin
        @(posedge clk); #2;
      end
      if (bus.mac_req_valid != '0) begin
        stb  |= bus.mac_req_valid;
        nstb++;
        swr   = bus.mac_req_wr;
        saddr = bus.mac_req_addr;
      end
      if (bus.req_ready != '0) extra = 1'b1;
      if (bus.resp_valid != '0) begin
        lat = c;
        rv  = bus.resp_valid;
        rd  = bus.resp_data;
        re  = bus.resp_err;
      end
    end
    bus.req_valid = '0;
    chk($sformatf("%s/latency", tag), 64'(lat), 64'(elat));
    chk($sformatf("%s/owner", tag), 64'(rv), 64'(1) << win);
    chk($sformatf("%s/data", tag), 64'(rd), 64'(edata));
    chk($sformatf("%s/err", tag), 64'(re), 64'(eerr));
    chk($sformatf("%s/strobe", tag), 64'(stb), 64'(estb));
    chk($sformatf("%s/nstrobe", tag), 64'(nstb), 64'(estb != '0));
    chk($sformatf("%s/regrant", tag), 64'(extra), 64'd0);
    if (nstb > 0) begin
      chk($sformatf("%s/wr", tag), 64'(swr), 64'(rq_wr[win]));
      chk($sformatf("%s/addr", tag), 64'(saddr), 64'(rq_addr[win]));
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = '1;
    bus.req_wr    = '0;
    bus.req_port  = '0;
    bus.req_addr  = '0;
    for (int p = 0; p < NP; p++) begin
      set_mac(p, 4, 32'h0);
      mb_busy[p] = 1'b0;
    end
    for (int r = 0; r < NR; r++) begin
      rq_wr[r]   = 1'b0;
      rq_port[r] = 0;
      rq_addr[r] = '0;
    end

    repeat (3) @(posedge clk);
    #2;
    chk_quiet("reset");
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    rq_port[0] = 0; rq_addr[0] = 8'h10;
    rq_port[1] = 1; rq_addr[1] = 8'h11;
    for (int k = 0; k < 4; k++) begin
      set_mac(0, 4, $urandom);
      set_mac(1, 4, $urandom);
      round(2'b11, 1'b0, $sformatf("alt%0d", k));
    end

    rq_port[0] = 2; rq_addr[0] = 8'h00;
    set_mac(2, 4, 32'h12345678);
    round(2'b01, 1'b0, "read");

    rq_wr[1] = 1'b1; rq_port[1] = 3; rq_addr[1] = 8'h0F;
    rq_port[0] = 0;
    round(2'b11, 1'b1, "write");
    rq_wr[1] = 1'b0;

    rq_port[0] = 5;
    round(2'b01, 1'b0, "badport");

    rq_port[0] = 4;
    set_mac(4, 0, 32'h0);
    round(2'b01, 1'b0, "timeout");

    rq_port[0] = 2;
    set_mac(2, 2, 32'hABCD0000);
    round(2'b01, 1'b0, "drop");

    rq_port[0] = 1; rq_addr[0] = 8'h5A;
    set_mac(1, 4, 32'hDEADBEEF);
    @(posedge clk); #1;
    drive_fields();
    bus.req_valid = 2'b01;
    #1;
    chk("abort/grant", 64'(bus.req_ready), 64'd1);
    cur_port = 1;
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (5) @(posedge clk);
    #3;
    bus.req_valid = 2'b11;
    rst = 1'b1;
    #1;
    chk_quiet("midrst");
    rr_m = 0;
    @(negedge clk); #1;
    rst = 1'b0;
    bus.req_valid = '0;

    rq_port[0] = 2; rq_addr[0] = 8'h22;
    rq_port[1] = 0; rq_addr[1] = 8'h33;
    set_mac(2, 4, 32'hCAFEF00D);
    set_mac(0, 4, 32'h01020304);
    round(2'b11, 1'b0, "postrst");

    noise_en = 1'b1;
    for (int k = 0; k < 24; k++) begin
      int x;
      for (int r = 0; r < NR; r++) begin
        rq_wr[r]   = ($urandom_range(0, 3) == 0);
        rq_port[r] = $urandom_range(0, 7);
        rq_addr[r] = 8'($urandom);
      end
      for (int p = 0; p < NP; p++) begin
        x = $urandom_range(0, 9);
        set_mac(p, (x < 6) ? 4 : x - 6, $urandom);
      end
      round(NR'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
            $sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
